pc_unit_ras: RTL and testbench

//  Parametrised PC generator for the single-cycle/multi-cycle core: holds the architectural PC and

---
 rtl/pc_unit_ras.sv | 193 +++++++++++++++++++
 tb/tb_pc_unit_ras.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// PC generator with commit handshake, misaligned-target fault FSM, external redirect and a circular RAS.
module pc_unit_ras #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(32'h80000000),
    parameter int unsigned            RAS_DEPTH  = 8,
    parameter int unsigned            ALIGN_BITS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           upd_valid,
    output logic                           upd_ready,
    input  logic [2:0]                     jump_kind,
    input  logic                           is_call,
    input  logic                           is_ret,
    input  logic [ADDR_WIDTH-1:0]          offset,
    input  logic [ADDR_WIDTH-1:0]          src1,
    input  logic                           branch_taken,
    input  logic [ADDR_WIDTH-1:0]          csr_pc,
    input  logic                           redirect_valid,
    input  logic [ADDR_WIDTH-1:0]          redirect_pc,
    output logic [ADDR_WIDTH-1:0]          pc,
    output logic [ADDR_WIDTH-1:0]          npc,
    output logic                           misalign,
    output logic [ADDR_WIDTH-1:0]          bad_target,
    output logic [ADDR_WIDTH-1:0]          ras_top,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_mismatch
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   badTarget_q, badTarget_d;
    logic                    misalign_q, misalign_d;
    logic                    rasMismatch_q, rasMismatch_d;
    logic [PTR_W-1:0]        rasPtr_q, rasPtr_d;
    logic [CNT_W-1:0]        rasCount_q, rasCount_d;
    logic [ADDR_WIDTH-1:0]   rasMem_q [RAS_DEPTH];

    logic [ADDR_WIDTH-1:0]   seqTarget;
    logic [ADDR_WIDTH-1:0]   jalTarget;
    logic [ADDR_WIDTH-1:0]   jalrTarget;
    logic [ADDR_WIDTH-1:0]   nextPc;
    logic                    needsAlign;
    logic                    misaligned;
    logic                    accept;
    logic                    applyUpdate;
    logic                    rasEmpty;
    logic [PTR_W-1:0]        rasTopIdx;
    logic [ADDR_WIDTH-1:0]   rasTopValue;
    logic                    rasWrEn;
    logic [PTR_W-1:0]        rasWrIdx;

    assign seqTarget  = pc_q + ADDR_WIDTH'(4);
    assign jalTarget  = pc_q + offset;
    assign jalrTarget = (src1 + offset) & ~ADDR_WIDTH'(1);

    always_comb begin
        nextPc = seqTarget;
        case (jump_kind)
            3'd0:    nextPc = jalTarget;
            3'd1:    nextPc = jalrTarget;
            3'd2:    nextPc = branch_taken ? jalTarget : seqTarget;
            3'd3:    nextPc = csr_pc;
            default: nextPc = seqTarget;
        endcase
    end

    // Trap/CSR targets are trusted; only control-flow targets from decode are alignment-checked.
    assign needsAlign  = (jump_kind == 3'd0) || (jump_kind == 3'd1) ||
                         ((jump_kind == 3'd2) && branch_taken);
    assign misaligned  = needsAlign && ((nextPc & ALIGN_MASK) != '0);
    assign upd_ready   = (state_q == ST_RUN);
    assign accept      = upd_valid && upd_ready;
    assign applyUpdate = accept && !redirect_valid && !misaligned;

    assign rasEmpty    = (rasCount_q == '0);
    assign rasTopIdx   = rasPtr_q - PTR_W'(1);
    assign rasTopValue = rasMem_q[rasTopIdx];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        badTarget_d = badTarget_q;
        misalign_d  = 1'b0;
        if (redirect_valid) begin
            pc_d        = redirect_pc;
            badTarget_d = '0;
            state_d     = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        if (misaligned) begin
                            badTarget_d = nextPc;
                            misalign_d  = 1'b1;
                            state_d     = ST_FAULT;
                        end else begin
                            pc_d = nextPc;
                        end
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Combined call+ret replaces the top entry in place, so depth is unchanged unless the stack was empty.
    always_comb begin
        rasPtr_d      = rasPtr_q;
        rasCount_d    = rasCount_q;
        rasWrEn       = 1'b0;
        rasWrIdx      = rasPtr_q;
        rasMismatch_d = 1'b0;
        if (applyUpdate) begin
            if (is_call && is_ret) begin
                rasWrEn = 1'b1;
                if (rasEmpty) begin
                    rasMismatch_d = 1'b1;
                    rasWrIdx      = rasPtr_q;
                    rasPtr_d      = rasPtr_q + PTR_W'(1);
                    rasCount_d    = CNT_W'(1);
                end else begin
                    rasMismatch_d = (rasTopValue != jalrTarget);
                    rasWrIdx      = rasTopIdx;
                end
            end else if (is_ret) begin
                if (rasEmpty) begin
                    rasMismatch_d = 1'b1;
                end else begin
                    rasMismatch_d = (rasTopValue != jalrTarget);
                    rasPtr_d      = rasTopIdx;
                    rasCount_d    = rasCount_q - CNT_W'(1);
                end
            end else if (is_call) begin
                rasWrEn    = 1'b1;
                rasWrIdx   = rasPtr_q;
                rasPtr_d   = rasPtr_q + PTR_W'(1);
                rasCount_d = (rasCount_q == CNT_MAX) ? rasCount_q : rasCount_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            badTarget_q   <= '0;
            misalign_q    <= 1'b0;
            rasMismatch_q <= 1'b0;
            rasPtr_q      <= '0;
            rasCount_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            badTarget_q   <= badTarget_d;
            misalign_q    <= misalign_d;
            rasMismatch_q <= rasMismatch_d;
            rasPtr_q      <= rasPtr_d;
            rasCount_q    <= rasCount_d;
        end
    end

    // Entry contents need no reset: ras_count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && rasWrEn) begin
            rasMem_q[rasWrIdx] <= seqTarget;
        end
    end

    assign pc           = pc_q;
    assign npc          = nextPc;
    assign misalign     = misalign_q;
    assign bad_target   = badTarget_q;
    assign ras_top      = rasEmpty ? '0 : rasTopValue;
    assign ras_count    = rasCount_q;
    assign ras_mismatch = rasMismatch_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Self-checking bench for pc_unit_ras: directed scenarios then randomized traffic against a queue-based model.
module tb_pc_unit_ras;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] RST_PC = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst, upd_valid, upd_ready, is_call, is_ret, branch_taken, redirect_valid;
    logic [2:0]  jump_kind;
    logic [31:0] offset, src1, csr_pc, redirect_pc, pc, npc, bad_target, ras_top;
    logic [3:0]  ras_count;
    logic        misalign, ras_mismatch;

    typedef struct {
        bit          rst;
        bit          rv;
        logic [31:0] rpc;
        bit          uv;
        logic [2:0]  kind;
        bit          call;
        bit          ret;
        logic [31:0] off;
        logic [31:0] s1;
        bit          tk;
        logic [31:0] cpc;
    } stim_t;

    logic [31:0] mPc;
    bit          mFault;
    logic [31:0] mBad;
    bit          mMisalign;
    bit          mMism;
    logic [31:0] mRas[$];

    int testsRun  = 0;
    int failCount = 0;

    pc_unit_ras #(.ADDR_WIDTH(32), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH), .ALIGN_BITS(2)) dut (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .jump_kind(jump_kind), .is_call(is_call), .is_ret(is_ret), .offset(offset),
        .src1(src1), .branch_taken(branch_taken), .csr_pc(csr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc), .npc(npc),
        .misalign(misalign), .bad_target(bad_target), .ras_top(ras_top),
        .ras_count(ras_count), .ras_mismatch(ras_mismatch)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.rv = 0; s.rpc = '0; s.uv = 0; s.kind = 3'd7; s.call = 0; s.ret = 0;
        s.off = '0; s.s1 = '0; s.tk = 0; s.cpc = '0;
        return s;
    endfunction

    // Architectural next-PC rule, evaluated from the model's own PC.
    function automatic logic [31:0] modelNpc(input stim_t s);
        case (s.kind)
            3'd0:    return mPc + s.off;
            3'd1:    return (s.s1 + s.off) & ~32'h1;
            3'd2:    return s.tk ? mPc + s.off : mPc + 32'd4;
            3'd3:    return s.cpc;
            default: return mPc + 32'd4;
        endcase
    endfunction

    task automatic modelStep(input stim_t s, input logic [31:0] n);
        logic [31:0] jalrT;
        logic [31:0] popped;
        bit          needs;
        jalrT     = (s.s1 + s.off) & ~32'h1;
        mMisalign = 0;
        mMism     = 0;
        if (s.rst) begin
            mPc = RST_PC; mFault = 0; mBad = '0; mRas.delete();
        end else if (s.rv) begin
            mPc = s.rpc; mFault = 0; mBad = '0;
        end else if (s.uv && !mFault) begin
            needs = (s.kind == 3'd0) || (s.kind == 3'd1) || (s.kind == 3'd2 && s.tk);
            if (needs && (n % 4) != 0) begin
                mFault = 1; mBad = n; mMisalign = 1;
            end else begin
                if (s.ret) begin
                    if (mRas.size() == 0) mMism = 1;
                    else begin
                        popped = mRas.pop_back();
                        if (popped != jalrT) mMism = 1;
                    end
                end
                if (s.call) begin
                    mRas.push_back(mPc + 32'd4);
                    if (mRas.size() > DEPTH) void'(mRas.pop_front());
                end
                mPc = n;
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        logic [31:0] expNpc;
        @(negedge clk);
        rst = s.rst; redirect_valid = s.rv; redirect_pc = s.rpc; upd_valid = s.uv;
        jump_kind = s.kind; is_call = s.call; is_ret = s.ret; offset = s.off;
        src1 = s.s1; branch_taken = s.tk; csr_pc = s.cpc;
        #1;
        expNpc = modelNpc(s);
        if (!s.rst) begin
            checkOutput("npc", 64'(npc), 64'(expNpc));
            checkOutput("upd_ready_pre", 64'(upd_ready), 64'(!mFault));
        end
        @(posedge clk);
        modelStep(s, expNpc);
        #1;
        checkOutput("pc", 64'(pc), 64'(mPc));
        checkOutput("upd_ready", 64'(upd_ready), 64'(!mFault));
        checkOutput("misalign", 64'(misalign), 64'(mMisalign));
        checkOutput("bad_target", 64'(bad_target), 64'(mBad));
        checkOutput("ras_count", 64'(ras_count), 64'(mRas.size()));
        checkOutput("ras_top", 64'(ras_top), 64'((mRas.size() > 0) ? mRas[$] : 32'h0));
        checkOutput("ras_mismatch", 64'(ras_mismatch), 64'(mMism));
    endtask

    initial begin
        stim_t s;
        int    r;
        rst = 1; redirect_valid = 0; redirect_pc = '0; upd_valid = 0; jump_kind = 3'd7;
        is_call = 0; is_ret = 0; offset = '0; src1 = '0; branch_taken = 0; csr_pc = '0;

        s = idle(); s.rst = 1; applyStimulus(s);
        checkOutput("reset_pc", 64'(pc), 64'(32'h80000000));
        s = idle(); s.uv = 1;
        repeat (3) applyStimulus(s);
        checkOutput("seq3_pc", 64'(pc), 64'(32'h8000000C));
        applyStimulus(s);

        s = idle(); s.uv = 1; s.kind = 3'd0; s.off = 32'h20; s.call = 1; applyStimulus(s);
        checkOutput("call_pc", 64'(pc), 64'(32'h80000030));
        checkOutput("call_top", 64'(ras_top), 64'(32'h80000014));
        s = idle(); s.uv = 1; s.kind = 3'd1; s.s1 = 32'h80000014; s.ret = 1; applyStimulus(s);
        checkOutput("ret_pc", 64'(pc), 64'(32'h80000014));
        checkOutput("ret_mism", 64'(ras_mismatch), 64'(0));

        s = idle(); s.uv = 1; s.kind = 3'd1; s.s1 = 32'h80000102; applyStimulus(s);
        checkOutput("fault_bad", 64'(bad_target), 64'(32'h80000102));
        checkOutput("fault_ready", 64'(upd_ready), 64'(0));
        s = idle(); s.uv = 1; applyStimulus(s);
        checkOutput("fault_hold_pc", 64'(pc), 64'(32'h80000014));
        s = idle(); s.rv = 1; s.rpc = 32'h80000200; applyStimulus(s);
        checkOutput("redirect_pc", 64'(pc), 64'(32'h80000200));

        for (int i = 0; i < 9; i++) begin
            s = idle(); s.uv = 1; s.kind = 3'd0; s.off = 32'h40; s.call = 1; applyStimulus(s);
        end
        checkOutput("ras_full", 64'(ras_count), 64'(8));
        for (int i = 0; i < 9; i++) begin
            s = idle(); s.uv = 1; s.kind = 3'd1; s.ret = 1;
            s.s1 = (mRas.size() > 0) ? mRas[$] : 32'h80001000;
            applyStimulus(s);
            if (i == 7) checkOutput("ret8_mism", 64'(ras_mismatch), 64'(0));
        end
        checkOutput("ret9_mism", 64'(ras_mismatch), 64'(1));

        s = idle(); s.rv = 1; s.rpc = 32'h80000300; s.uv = 1; s.kind = 3'd0; s.off = 32'h40; s.call = 1;
        applyStimulus(s);
        checkOutput("redir_nopush", 64'(ras_count), 64'(0));
        s = idle(); s.uv = 1; s.kind = 3'd0; s.off = 32'h40; s.call = 1; applyStimulus(s);
        s = idle(); s.uv = 1; s.kind = 3'd1; s.s1 = 32'h80000500; s.ret = 1; applyStimulus(s);
        checkOutput("badret_mism", 64'(ras_mismatch), 64'(1));
        checkOutput("badret_pc", 64'(pc), 64'(32'h80000500));
        s = idle(); s.uv = 1; s.kind = 3'd1; s.s1 = 32'h80000600; s.ret = 1; s.call = 1; applyStimulus(s);
        checkOutput("callret_empty", 64'(ras_count), 64'(1));
        s = idle(); s.uv = 1; s.kind = 3'd0; s.off = 32'h2; applyStimulus(s);
        s = idle(); s.rst = 1; applyStimulus(s);
        checkOutput("rst_fault_ready", 64'(upd_ready), 64'(1));

        for (int i = 0; i < 2000; i++) begin
            s = idle();
            s.rst  = ($urandom_range(0, 99) == 0);
            s.rv   = ($urandom_range(0, 15) == 0) || (mFault && $urandom_range(0, 2) == 0);
            s.rpc  = 32'h80000000 + ($urandom_range(0, 4095) << 2);
            s.uv   = ($urandom_range(0, 3) != 0);
            s.kind = 3'($urandom_range(0, 7));
            s.tk   = 1'($urandom_range(0, 1));
            s.off  = ($urandom_range(0, 255) << 2) - 32'd512;
            if ($urandom_range(0, 9) == 0) s.off = s.off + $urandom_range(1, 3);
            s.s1   = 32'h80000000 + $urandom_range(0, 65535);
            s.cpc  = 32'h80000000 + ($urandom_range(0, 1023) << 2);
            if ($urandom_range(0, 9) == 0) s.cpc = s.cpc + 32'd2;
            s.call = ($urandom_range(0, 5) == 0);
            s.ret  = ($urandom_range(0, 5) == 0);
            if (s.ret) begin
                s.kind = 3'd1;
                r = int'($urandom_range(0, 3));
                if (mRas.size() > 0 && r != 0) s.s1 = mRas[$] - s.off;
            end else if (s.call) begin
                s.kind = 3'($urandom_range(0, 1));
            end
            applyStimulus(s);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
